irst_rekey_engine: RTL and testbench



---
 rtl/irst_rekey_engine_pkg.sv | 40 ++++
 rtl/irst_rekey_engine_lfsr.sv | 61 ++++++
 rtl/irst_rekey_engine.sv | 219 +++++++++++++++++++++
 tb/tb_irst_rekey_engine.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irst_rekey_engine_pkg.sv
// ---------------------------------------------------------------------------
// irst_rekey_engine_pkg
//
// Shared definitions for the instruction-randomization rekey engine:
//   - rekey_state_e : FSM state encoding, also exposed on the engine's
//                     dbg_state output so checkers can bind to it.
//   - TAPS_W8/16/32 : default Galois feedback masks for common key widths.
//   - default_taps(): picks the default mask for a given key width.
//
// Optional feature macro used by the engine: IRST_VERIFY_EN (adds the
// VERIFY state; the encoding below always reserves a code for it so the
// debug view is identical in both builds).
// ---------------------------------------------------------------------------
package irst_rekey_engine_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_VERIFY = 3'd4,
    ST_SWAP   = 3'd5
  } rekey_state_e;

  // Right-shifting Galois masks (bit 0 is the output tap).
  localparam logic [31:0] TAPS_W8  = 32'h0000_00B8;
  localparam logic [31:0] TAPS_W16 = 32'h0000_B400;
  localparam logic [31:0] TAPS_W32 = 32'h8020_0003;

  // Widths without a dedicated entry fall back to the 16-bit mask; pass an
  // explicit LFSR_TAPS for those if a maximal-length sequence matters.
  function automatic logic [31:0] default_taps(input int width);
    case (width)
      8:       return TAPS_W8;
      32:      return TAPS_W32;
      default: return TAPS_W16;
    endcase
  endfunction

endpackage

// File: rtl/irst_rekey_engine_lfsr.sv
// ---------------------------------------------------------------------------
// irst_lfsr
//
// Parametrised right-shifting Galois LFSR with a zero-state guard. The
// state can never become zero: any step that would produce zero yields 1.
//
// Ports:
//   clk       in  1  clock
//   rst       in  1  synchronous active-high reset (state <= RESET_VAL | 1)
//   load      in  1  state <= guard(step(state ^ load_val)); wins over step
//   step      in  1  state <= guard(step(state))
//   load_val  in  W  value mixed into the state on load
//   load_next out W  value the state takes if load is asserted this cycle
//   value     out W  current state
// ---------------------------------------------------------------------------
module irst_lfsr #(
  parameter int           W         = 16,
  parameter logic [W-1:0] TAPS      = 16'hB400,
  parameter logic [W-1:0] RESET_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         step,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] load_next,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  logic [W-1:0] state_q;
  logic [W-1:0] step_next;

  // One Galois step: shift right, fold the taps in when a 1 falls out.
  function automatic logic [W-1:0] galois(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ TAPS;
    return r;
  endfunction

  function automatic logic [W-1:0] nonzero(input logic [W-1:0] v);
    return (v == '0) ? ONE : v;
  endfunction

  assign load_next = nonzero(galois(state_q ^ load_val));
  assign step_next = nonzero(galois(state_q));
  assign value     = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RESET_VAL | ONE;
    end else if (load) begin
      state_q <= load_next;
    end else if (step) begin
      state_q <= step_next;
    end
  end

endmodule

// File: rtl/irst_rekey_engine.sv
// ---------------------------------------------------------------------------
// irst_rekey_engine
//
// Walks the whole instruction memory and re-encrypts every word in place:
//   new_word = stored_word ^ active_key ^ new_key
// The new key comes from an internal LFSR (irst_lfsr), seeded by XORing
// `seed` into its state when a pass begins. The pipeline is held stalled
// for the whole pass and the decode key is swapped in the same cycle the
// stall releases, so no fetch ever decodes with a half-updated key.
//
// Parameters:
//   DATA_W     instruction/key width (8..32)
//   ADDR_W     instruction memory address width
//   DEPTH      number of words processed (1 .. 2**ADDR_W)
//   LFSR_TAPS  Galois feedback mask (low DATA_W bits used)
//   KEY_RESET  active key after reset
//   AUTO_START 1: a pass runs automatically right after reset releases
//
// Ports:
//   clk               in   1       core clock
//   rst               in   1       synchronous active-high reset
//   start             in   1       rekey request, sampled only in IDLE
//   seed              in   DATA_W  mixed into the LFSR at LOAD
//   busy              out  1       high from LOAD through the last word
//   done              out  1       one-cycle pulse when the key swap lands
//   pipeline_stall_n  out  1       0 while a pass is running
//   active_key        out  DATA_W  key used by the decode randomizer
//   dbg_state         out  3       current FSM state (rekey_state_e)
//   imem_addr         out  ADDR_W  instruction memory address
//   imem_rd_data      in   DATA_W  read data, valid one cycle after imem_addr
//   imem_wr_en        out  1       write strobe
//   imem_wr_data      out  DATA_W  re-encrypted word (0 when not writing)
//   verify_err        out  1       only with IRST_VERIFY_EN: sticky
//                                  read-back mismatch flag
//
// Optional feature macro: IRST_VERIFY_EN. When defined, every WRITE is
// followed by a VERIFY cycle that compares the re-read word with what was
// written; any mismatch sets verify_err and suppresses the key swap (done
// still pulses). The memory is expected to return the newly written word
// when read in the cycle after the write (write-through read port).
//
// Handshake: start is a request with no ready; it is honoured only when the
// FSM is IDLE and is otherwise dropped (never queued). busy/pipeline_stall_n
// are the "in progress" indication and done is a single-cycle completion
// pulse coincident with the new active_key and the stall release.
// ---------------------------------------------------------------------------
module irst_rekey_engine
  import irst_rekey_engine_pkg::*;
#(
  parameter int          DATA_W     = 16,
  parameter int          ADDR_W     = 8,
  parameter int          DEPTH      = 256,
  parameter logic [31:0] LFSR_TAPS  = default_taps(DATA_W),
  parameter logic [31:0] KEY_RESET  = 32'h0,
  parameter bit          AUTO_START = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pipeline_stall_n,
  output logic [DATA_W-1:0] active_key,
  output logic [2:0]        dbg_state,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rd_data,
  output logic              imem_wr_en,
  output logic [DATA_W-1:0] imem_wr_data
`ifdef IRST_VERIFY_EN
  ,
  output logic              verify_err
`endif
);

  localparam logic [DATA_W-1:0] KEY_RST   = KEY_RESET[DATA_W-1:0];
  localparam logic [DATA_W-1:0] TAPS      = LFSR_TAPS[DATA_W-1:0];
  // One extra address bit so DEPTH == 2**ADDR_W reaches its last word
  // without the counter wrapping back to zero first.
  localparam logic [ADDR_W:0]   LAST_ADDR = (ADDR_W+1)'(DEPTH - 1);

  rekey_state_e      state_q;
  logic [ADDR_W:0]   addr_q;
  logic [DATA_W-1:0] new_key_q;
  logic              pending_q;
  logic [DATA_W-1:0] lfsr_next;
  logic [DATA_W-1:0] lfsr_value;
  logic              lfsr_load;
  logic              last_word;
  logic              word_done;
  logic              swap_ok;

  assign dbg_state = state_q;
  assign imem_addr = addr_q[ADDR_W-1:0];
  assign last_word = (addr_q == LAST_ADDR);
  assign lfsr_load = (state_q == ST_LOAD);

  // Write data is formed from the read data that arrives in the WRITE
  // cycle itself, so it cannot be registered without adding a cycle per
  // word; it is forced to zero whenever the strobe is low.
  assign imem_wr_data = imem_wr_en ? (imem_rd_data ^ active_key ^ new_key_q)
                                   : '0;

`ifdef IRST_VERIFY_EN
  logic [DATA_W-1:0] wr_word_q;
  logic              verify_mismatch;

  assign verify_mismatch = (state_q == ST_VERIFY) && (imem_rd_data != wr_word_q);
  assign word_done       = (state_q == ST_VERIFY);
  // The last word's check lands in the same cycle as the swap decision.
  assign swap_ok         = !(verify_err || verify_mismatch);
`else
  assign word_done       = (state_q == ST_WRITE);
  assign swap_ok         = 1'b1;
`endif

  irst_lfsr #(
    .W         (DATA_W),
    .TAPS      (TAPS),
    .RESET_VAL (KEY_RST)
  ) u_lfsr (
    .clk       (clk),
    .rst       (rst),
    .load      (lfsr_load),
    .step      (1'b0),
    .load_val  (seed),
    .load_next (lfsr_next),
    .value     (lfsr_value)
  );

  // Kept for debug visibility of the generator; the engine only needs
  // the value the LFSR is about to take at LOAD.
  logic lfsr_unused;
  assign lfsr_unused = ^lfsr_value;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      pending_q        <= AUTO_START;
      busy             <= 1'b0;
      done             <= 1'b0;
      pipeline_stall_n <= 1'b1;
      imem_wr_en       <= 1'b0;
      addr_q           <= '0;
      new_key_q        <= KEY_RST;
      active_key       <= KEY_RST;
`ifdef IRST_VERIFY_EN
      wr_word_q        <= '0;
      verify_err       <= 1'b0;
`endif
    end else begin
      done <= 1'b0;

      case (state_q)
        ST_IDLE: begin
          if (start || pending_q) begin
            pending_q        <= 1'b0;
            busy             <= 1'b1;
            pipeline_stall_n <= 1'b0;
            state_q          <= ST_LOAD;
`ifdef IRST_VERIFY_EN
            verify_err       <= 1'b0;
`endif
          end
        end

        ST_LOAD: begin
          // The LFSR takes the same value this cycle (lfsr_load is high).
          new_key_q <= lfsr_next;
          addr_q    <= '0;
          state_q   <= ST_READ;
        end

        ST_READ: begin
          imem_wr_en <= 1'b1;
          state_q    <= ST_WRITE;
        end

        ST_WRITE: begin
          imem_wr_en <= 1'b0;
`ifdef IRST_VERIFY_EN
          wr_word_q  <= imem_wr_data;
          state_q    <= ST_VERIFY;
`endif
        end

`ifdef IRST_VERIFY_EN
        ST_VERIFY: begin
          if (verify_mismatch) verify_err <= 1'b1;
        end
`endif

        ST_SWAP: begin
          state_q <= ST_IDLE;
        end

        default: begin
          state_q <= ST_IDLE;
        end
      endcase

      // End of one word: either step to the next address or finish the
      // pass. Stall release, done and the key swap share one edge.
      if (word_done) begin
        if (last_word) begin
          state_q          <= ST_SWAP;
          busy             <= 1'b0;
          done             <= 1'b1;
          pipeline_stall_n <= 1'b1;
          if (swap_ok) active_key <= new_key_q;
        end else begin
          addr_q  <= addr_q + 1'b1;
          state_q <= ST_READ;
        end
      end
    end
  end

endmodule

// File: tb/tb_irst_rekey_engine.sv
// ---------------------------------------------------------------------------
// tb_irst_rekey_engine
//
// Bench for irst_rekey_engine with DATA_W=16, ADDR_W=3, DEPTH=8 (a full
// address space), KEY_RESET=0, AUTO_START=1. A behavioural synchronous
// memory with a write-through read port sits on the imem interface.
// Each table row is one rekey pass; the expected new key comes from a
// software model of the Galois LFSR, and every expected memory write is
// queued when the pass is launched and popped as the DUT writes.
// ---------------------------------------------------------------------------
module tb_irst_rekey_engine;
  import irst_rekey_engine_pkg::*;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 3;
  localparam int DEPTH  = 8;
`ifdef IRST_VERIFY_EN
  localparam int PER = 3;
`else
  localparam int PER = 2;
`endif
  localparam int DONE_CYC = PER * DEPTH + 2;
  localparam int WINDOW   = 2 * PER * DEPTH + 6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst;
  logic              start;
  logic [DATA_W-1:0] seed;
  logic              busy;
  logic              done;
  logic              pipeline_stall_n;
  logic [DATA_W-1:0] active_key;
  logic [2:0]        dbg_state;
  logic [ADDR_W-1:0] imem_addr;
  logic [DATA_W-1:0] imem_rd_data;
  logic              imem_wr_en;
  logic [DATA_W-1:0] imem_wr_data;
`ifdef IRST_VERIFY_EN
  logic              verify_err;
`endif

  irst_rekey_engine #(
    .DATA_W     (DATA_W),
    .ADDR_W     (ADDR_W),
    .DEPTH      (DEPTH),
    .LFSR_TAPS  (32'h0000_B400),
    .KEY_RESET  (32'h0),
    .AUTO_START (1'b1)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .seed             (seed),
    .busy             (busy),
    .done             (done),
    .pipeline_stall_n (pipeline_stall_n),
    .active_key       (active_key),
    .dbg_state        (dbg_state),
    .imem_addr        (imem_addr),
    .imem_rd_data     (imem_rd_data),
    .imem_wr_en       (imem_wr_en),
    .imem_wr_data     (imem_wr_data)
`ifdef IRST_VERIFY_EN
    ,
    .verify_err       (verify_err)
`endif
  );

  // ---------------- memory model ----------------
  logic [DATA_W-1:0] mem   [DEPTH];
  logic [DATA_W-1:0] plain [DEPTH];
  logic              load_req;
  logic              corrupt_en;
  logic [DATA_W-1:0] store_val;

  always_comb store_val = (corrupt_en && imem_addr == 3'd3) ? (imem_wr_data ^ 16'h0040)
                                                            : imem_wr_data;

  always @(posedge clk) begin
    if (load_req) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= plain[i];
      imem_rd_data <= plain[imem_addr];
    end else begin
      if (imem_wr_en) mem[imem_addr] <= store_val;
      imem_rd_data <= imem_wr_en ? store_val : mem[imem_addr];
    end
  end

  // ---------------- checking ----------------
  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  logic [ADDR_W+DATA_W-1:0] exp_q[$];

  always @(negedge clk) begin
    if (imem_wr_en === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL wr_unexpected: got addr %h data %h with no write expected",
                 imem_addr, imem_wr_data);
      end else begin
        logic [ADDR_W+DATA_W-1:0] e;
        e = exp_q.pop_front();
        check("wr_addr_data", {imem_addr, imem_wr_data}, e);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("%0d/%0d checks passed", n_pass, n_total + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [DATA_W-1:0] model_step(input logic [DATA_W-1:0] v);
    logic [DATA_W-1:0] r;
    r = v >> 1;
    if (v[0]) r = r ^ 16'hB400;
    return (r == '0) ? 16'h0001 : r;
  endfunction

  logic [DATA_W-1:0] ref_mem [DEPTH];
  logic [DATA_W-1:0] model_key;
  logic [DATA_W-1:0] model_lfsr;

  typedef struct {
    logic              use_start;   // 0: pass is the automatic one after reset
    logic              fresh_reset; // reset (abort if mid-run) precedes this row
    logic              zero_guard;  // seed chosen equal to LFSR state
    logic              corrupt;     // memory corrupts the write at address 3
    logic [DATA_W-1:0] seed;
    int                pulse_cyc;   // extra start pulse at this cycle (0: none)
    logic              has_hand;
    logic [DATA_W-1:0] hand_key;    // hand-derived expected key
    logic [DATA_W-1:0] new_key;     // expected LFSR output for the pass
    int                exp_done_cyc;
    int                exp_done_cnt;
    logic              exp_swap;
  } vec_t;

  vec_t tbl[$];

  task automatic add_row(input logic use_start, input logic fresh_reset,
                         input logic zero_guard, input logic corrupt,
                         input logic [DATA_W-1:0] sd, input int pulse_cyc,
                         input logic has_hand, input logic [DATA_W-1:0] hand_key);
    vec_t v;
    v.use_start    = use_start;
    v.fresh_reset  = fresh_reset;
    v.zero_guard   = zero_guard;
    v.corrupt      = corrupt;
    v.seed         = sd;
    v.pulse_cyc    = pulse_cyc;
    v.has_hand     = has_hand;
    v.hand_key     = hand_key;
    v.new_key      = '0;
    v.exp_done_cyc = DONE_CYC;
    v.exp_done_cnt = 1;
    v.exp_swap     = !corrupt;
    tbl.push_back(v);
  endtask

  // ---------------- driver: one full pass ----------------
  // Entered at a falling edge that is cycle 0 of the pass.
  task automatic run_pass(input vec_t v);
    int done_cyc, done_cnt, stall_first, stall_last, stall_cnt, busy_cnt, bad;
    logic [DATA_W-1:0] key_pre;
    seed = v.seed;
    for (int i = 0; i < DEPTH; i++)
      exp_q.push_back({ADDR_W'(i), ref_mem[i] ^ model_key ^ v.new_key});
    corrupt_en = v.corrupt;
    if (v.use_start) start = 1'b1;
    done_cyc = -1; done_cnt = 0; stall_first = -1; stall_last = -1;
    stall_cnt = 0; busy_cnt = 0; key_pre = '0;
    for (int n = 1; n <= WINDOW; n++) begin
      @(negedge clk);
      if (n == 1) start = 1'b0;
      if (v.pulse_cyc > 1 && n == v.pulse_cyc) begin
        check("pulse_in_rw", 32'(dbg_state == 3'(ST_READ) || dbg_state == 3'(ST_WRITE)), 1);
        start = 1'b1;
      end else if (v.pulse_cyc > 1 && n == v.pulse_cyc + 1) begin
        start = 1'b0;
      end
      if (busy) busy_cnt++;
      if (!pipeline_stall_n) begin
        stall_cnt++;
        if (stall_first < 0) stall_first = n;
        stall_last = n;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
      if (done_cyc < 0) key_pre = active_key;
    end
    corrupt_en = 1'b0;

    check("done_cycle",  32'(done_cyc),    32'(v.exp_done_cyc));
    check("done_count",  32'(done_cnt),    32'(v.exp_done_cnt));
    check("stall_first", 32'(stall_first), 32'd1);
    check("stall_last",  32'(stall_last),  32'(DONE_CYC - 1));
    check("stall_count", 32'(stall_cnt),   32'(DONE_CYC - 1));
    check("busy_count",  32'(busy_cnt),    32'(DONE_CYC - 1));
    check("key_before_swap", key_pre, model_key);
    check("writes_seen", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    check("active_key", active_key, v.exp_swap ? v.new_key : model_key);
    if (v.has_hand) check("active_key_hand", active_key, v.hand_key);
`ifdef IRST_VERIFY_EN
    check("verify_err", verify_err, !v.exp_swap);
`endif
    model_lfsr = v.new_key;
    if (v.exp_swap) begin
      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (mem[i] !== (plain[i] ^ v.new_key)) bad++;
      check("mem_plain_xor_key", 32'(bad), 32'd0);
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = ref_mem[i] ^ model_key ^ v.new_key;
      model_key = v.new_key;
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [DATA_W-1:0] chain;

    rst = 1'b1; load_req = 1'b1; corrupt_en = 1'b0; start = 1'b0; seed = '0;
    for (int i = 0; i < DEPTH; i++) plain[i] = 16'h1000 + 16'(i);

    // use_start fresh zg corrupt seed pulse hand key
    add_row(1'b0, 1'b1, 1'b0, 1'b0, 16'h0001, 0, 1'b1, 16'h0001); // auto, seed==lfsr
    add_row(1'b1, 1'b0, 1'b0, 1'b0, 16'h5A5A, 0, 1'b0, 16'h0000);
    add_row(1'b1, 1'b0, 1'b0, 1'b0, 16'hC3E1, 2, 1'b0, 16'h0000); // start in READ
    add_row(1'b1, 1'b0, 1'b0, 1'b0, 16'h0F0F, 3, 1'b0, 16'h0000); // start in WRITE
    add_row(1'b1, 1'b0, 1'b1, 1'b0, 16'h0000, 0, 1'b1, 16'h0001); // zero guard
    add_row(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 0, 1'b0, 16'h0000);
    add_row(1'b0, 1'b1, 1'b0, 1'b0, 16'h0002, 0, 1'b1, 16'hB401); // after abort
`ifdef IRST_VERIFY_EN
    add_row(1'b1, 1'b0, 1'b0, 1'b1, 16'h3C3C, 0, 1'b0, 16'h0000); // corrupt @3
`endif

    chain = 16'h0001;
    foreach (tbl[i]) begin
      if (tbl[i].fresh_reset) chain = 16'h0001;
      if (tbl[i].zero_guard) tbl[i].seed = chain;
      tbl[i].new_key = model_step(chain ^ tbl[i].seed);
      chain = tbl[i].new_key;
    end

    foreach (tbl[r]) begin
      if (r == 0) begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy",   busy, 0);
        check("rst_done",   done, 0);
        check("rst_stall_n", pipeline_stall_n, 1);
        check("rst_wr_en",  imem_wr_en, 0);
        check("rst_addr",   imem_addr, 0);
        check("rst_wr_data", imem_wr_data, 0);
        check("rst_key",    active_key, 0);
        check("rst_state",  dbg_state, 3'(ST_IDLE));
`ifdef IRST_VERIFY_EN
        check("rst_verify_err", verify_err, 0);
`endif
      end else if (tbl[r].fresh_reset) begin
        // Launch a pass and abort it with reset at cycle 7.
        seed = 16'h1234;
        for (int i = 0; i < DEPTH; i++)
          exp_q.push_back({ADDR_W'(i), ref_mem[i] ^ model_key ^ model_step(model_lfsr ^ seed)});
        start = 1'b1;
        for (int n = 1; n <= 7; n++) begin
          @(negedge clk);
          if (n == 1) start = 1'b0;
        end
        check("abort_busy_before", busy, 1);
        rst = 1'b1; load_req = 1'b1;
        @(negedge clk);
        check("abort_busy",    busy, 0);
        check("abort_key",     active_key, 0);
        check("abort_wr_en",   imem_wr_en, 0);
        check("abort_stall_n", pipeline_stall_n, 1);
        check("abort_done",    done, 0);
        check("abort_state",   dbg_state, 3'(ST_IDLE));
        exp_q.delete();
      end
      if (tbl[r].fresh_reset) begin
        model_key  = '0;
        model_lfsr = 16'h0001;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = plain[i];
        rst = 1'b0; load_req = 1'b0;
      end
      run_pass(tbl[r]);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
